// File: rtl/parking_billing.sv
// Billing stage of the parking controller: fee pipeline, bill FIFO and revenue total.
// Optional free-parking grace period is enabled with the BILLING_GRACE_EN macro.
module parking_billing #(
    parameter int UNIT_SHIFT  = 4,
    parameter int RATE        = 5,
    parameter int MAX_FEE     = 500,
    parameter int GRACE_TICKS = 20,
    parameter int DEPTH       = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     exit_evt,
    input  logic [1:0]               switch,
    input  logic [63:0]              spot0_time,
    input  logic [63:0]              spot1_time,
    input  logic [63:0]              spot2_time,
    input  logic [63:0]              spot3_time,
    output logic                     bill_valid,
    input  logic                     bill_ready,
    output logic [1:0]               bill_spot,
    output logic [15:0]              bill_fee,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [31:0]              revenue,
    output logic                     overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [64:0] ROUND_C   = 65'((65'd1 << UNIT_SHIFT) - 65'd1);
    localparam logic [64:0] MAX_FEE_C = 65'(MAX_FEE);
    localparam logic [64:0] RATE_C    = 65'(RATE);
    localparam logic [63:0] GRACE_C   = 64'(GRACE_TICKS);
    localparam logic [15:0] FEE_CAP_C = 16'(MAX_FEE);
`ifdef BILLING_GRACE_EN
    localparam logic GRACE_EN = 1'b1;
`else
    localparam logic GRACE_EN = 1'b0;
`endif

    logic               s1_vld_r;
    logic [1:0]         s1_spot_r;
    logic [63:0]        s1_time_r;
    logic               s2_vld_r;
    logic [1:0]         s2_spot_r;
    logic [15:0]        s2_fee_r;

    logic [63:0]        sel_time_s;
    logic [64:0]        units_s;
    logic [64:0]        prod_s;
    logic [15:0]        fee_s;

    logic [1:0]         mem_spot_r [DEPTH];
    logic [15:0]        mem_fee_r  [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [31:0]        revenue_r;
    logic               overflow_r;

    logic               full_s;
    logic               pop_s;
    logic               push_ok_s;
    logic [32:0]        rev_sum_s;

    // Spot time multiplexer driven by the exit's spot index
    always_comb begin
        sel_time_s = 64'd0;
        case (switch)
            2'd0:    sel_time_s = spot0_time;
            2'd1:    sel_time_s = spot1_time;
            2'd2:    sel_time_s = spot2_time;
            2'd3:    sel_time_s = spot3_time;
            default: sel_time_s = 64'd0;
        endcase
    end

    // Fee computation: ceiling units, cap before multiplying so the product stays small
    always_comb begin
        units_s = ({1'b0, s1_time_r} + ROUND_C) >> UNIT_SHIFT;
        prod_s  = 65'd0;
        fee_s   = 16'd0;
        if (units_s > MAX_FEE_C) begin
            fee_s = FEE_CAP_C;
        end else begin
            prod_s = units_s * RATE_C;
            if (prod_s > MAX_FEE_C) begin
                fee_s = FEE_CAP_C;
            end else begin
                fee_s = prod_s[15:0];
            end
        end
        if (GRACE_EN && (s1_time_r < GRACE_C)) begin
            fee_s = 16'd0;
        end else begin
            fee_s = fee_s;
        end
    end

    // Capture and compute stages; never stalled
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_vld_r  <= 1'b0;
            s1_spot_r <= 2'd0;
            s1_time_r <= 64'd0;
            s2_vld_r  <= 1'b0;
            s2_spot_r <= 2'd0;
            s2_fee_r  <= 16'd0;
        end else begin
            s1_vld_r  <= exit_evt;
            if (exit_evt) begin
                s1_spot_r <= switch;
                s1_time_r <= sel_time_s;
            end
            s2_vld_r  <= s1_vld_r;
            if (s1_vld_r) begin
                s2_spot_r <= s1_spot_r;
                s2_fee_r  <= fee_s;
            end
        end
    end

    assign full_s     = (count_r == CW'(DEPTH));
    assign bill_valid = (count_r != {CW{1'b0}});
    assign pop_s      = bill_valid && bill_ready;
    // A full FIFO still accepts the write when the head leaves in the same cycle
    assign push_ok_s  = s2_vld_r && (!full_s || pop_s);
    assign rev_sum_s  = {1'b0, revenue_r} + {17'd0, bill_fee};

    // Bill FIFO, revenue accumulator and sticky drop flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_spot_r[i] <= 2'd0;
                mem_fee_r[i]  <= 16'd0;
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            revenue_r  <= 32'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_spot_r[wr_ptr_r] <= s2_spot_r;
                mem_fee_r[wr_ptr_r]  <= s2_fee_r;
                wr_ptr_r             <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (s2_vld_r && !push_ok_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
                revenue_r <= rev_sum_s[32] ? 32'hFFFF_FFFF : rev_sum_s[31:0];
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign bill_spot    = bill_valid ? mem_spot_r[rd_ptr_r] : 2'd0;
    assign bill_fee     = bill_valid ? mem_fee_r[rd_ptr_r]  : 16'd0;
    assign pending      = count_r;
    assign revenue      = revenue_r;
    assign overflow_err = overflow_r;

endmodule

// File: doc/parking_billing.md
# parking_billing

Downstream billing stage of the parking controller. It consumes the controller's exit event, the selected spot number and the four per-spot occupancy timers. For each exit it computes a saturating parking fee and queues the resulting bill in a small FIFO. A payment/display unit drains the FIFO over a valid/ready handshake, and the block keeps a running revenue total.

## Interface
Parameters:
- UNIT_SHIFT, 4: billing unit is 2^UNIT_SHIFT clock ticks.
- RATE, 5: fee per started unit.
- MAX_FEE, 500: fee cap; must be ≤ 65535.
- GRACE_TICKS, 20: free-parking threshold; used only with BILLING_GRACE_EN.
- DEPTH, 4: bill FIFO entries; power of two, ≥ 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- exit_evt  in  1  one-cycle pulse: a car leaves spot `switch`.
- switch  in  2  spot index of the exiting car.
- spot0_time..spot3_time  in  64 each  ticks the spot has been occupied, valid in the exit_evt cycle.
- bill_valid  out  1  FIFO head holds a bill.
- bill_ready  in  1  consumer accepts the head this cycle.
- bill_spot  out  2  spot index of the head bill.
- bill_fee  out  16  fee of the head bill.
- pending  out  $clog2(DEPTH)+1  bills queued.
- revenue  out  32  sum of accepted fees, saturating at 0xFFFFFFFF.
- overflow_err  out  1  sticky flag: a bill was dropped.

## Operation
- Pipeline stages:
  - S1 (capture): on exit_evt, register the spot index and the selected 64-bit time. Set s1_vld.
  - S2 (compute): register the fee. Set s2_vld.
  - WR: S2 writes into the FIFO.
- S1 and S2 are never stalled. The pipeline accepts one exit per cycle.
- Fee arithmetic, 65-bit intermediate:
  - units = (time + 2^UNIT_SHIFT − 1) >> UNIT_SHIFT, i.e. ceiling.
  - If units > MAX_FEE, fee = MAX_FEE, so the multiply never overflows.
  - Otherwise fee = min(units × RATE, MAX_FEE).
  - time = 0 gives fee 0.
- FIFO: DEPTH entries of {spot, fee}, with wrap-around read/write pointers.
  - Head is shown combinationally on bill_spot/bill_fee.
  - bill_valid = (pending ≠ 0).
  - A pop occurs when bill_valid && bill_ready.
  - bill_spot/bill_fee are don't-care while bill_valid = 0; a bench must not check them then.
- Full FIFO:
  - A write with no simultaneous pop drops the bill, sets overflow_err, and leaves pending at DEPTH.
  - Write and pop in the same cycle both succeed; pending stays DEPTH.
- Empty FIFO: bill_ready is ignored and pending stays 0.
- revenue += bill_fee on each pop, saturating add.
- overflow_err clears only on reset.
- An exit_evt with switch out of range cannot occur: switch is always 0..3.

## Timing
- Reset (RST = 0, asynchronous):
  - bill_valid = 0, pending = 0, revenue = 0, overflow_err = 0.
  - bill_spot = 0, bill_fee = 0.
  - s1_vld = s2_vld = 0, FIFO pointers = 0.
- Reset mid-operation discards all in-flight and queued bills.
- Latency: exit_evt sampled at edge k → S1 at k, S2 at k+1, FIFO write at k+2.
  - On an empty FIFO, bill_valid is high after edge k+2.
  - pending increments at edge k+2.
- Pop takes effect at the edge where bill_valid && bill_ready. The next head is visible after that edge.
- revenue updates at the pop edge.
- overflow_err rises at the edge of the dropped write.

## Configuration
- BILLING_GRACE_EN defined: in S2, time < GRACE_TICKS forces fee = 0. The bill is still queued.
- BILLING_GRACE_EN undefined: GRACE_TICKS is ignored and every exit uses the plain fee formula.

## Test plan
All scenarios use default parameters.
1. Reset: hold RST = 0, toggle inputs → bill_valid = 0, pending = 0, revenue = 0, overflow_err = 0. Release RST → outputs unchanged.
2. Basic bill: exit_evt, switch = 2, spot2_time = 100, bill_ready = 0.
   - bill_valid rises after the 3rd edge; bill_spot = 2, bill_fee = 35, pending = 1.
   - Then pulse bill_ready → pending = 0, revenue = 35.
3. Grace and zero:
   - spot1_time = 15 → fee 0 with BILLING_GRACE_EN, 5 without.
   - spot0_time = 0 → fee 0 in both builds.
4. Saturation: spot3_time = 2000 → fee 500. spot3_time = 0xFFFF_FFFF_FFFF_FFFF → fee 500.
5. Overflow and wrap: 5 back-to-back exits, bill_ready = 0.
   - Result: pending = 4, overflow_err = 1, the 5th bill is dropped.
   - Drain 4 bills → values and order match the first 4 exits, revenue equals their sum.
   - Repeat 3 rounds of 3 bills to exercise pointer wrap.
   - Also: write on a full FIFO with bill_ready = 1 in the same cycle → no drop.
6. Reset mid-operation: 2 bills queued plus 1 in S2, assert RST → pending = 0, bill_valid = 0. No bill appears after release.
